mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one registered mux datapath between NREQ requesters.
- Lets the NOR/XOR/NAND logic cones feed a single select-driven output register instead of a hard-wired select.
- Decides ownership, drives a one-hot grant and a binary select, and registers the selected data, with a bounded hold time per grant.
- Sits between the requesting logic blocks and the downstream D flip-flop stage.

---
 rtl/mux_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered mux between NREQ requesters.
// Grants are one-hot with a binary select; each owner is capped at MAXHOLD consecutive cycles.
module mux_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 1,
  parameter int MAXHOLD = 4,
  localparam int SW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data_in,
  output logic [NREQ-1:0]      gnt,
  output logic [SW-1:0]        sel,
  output logic [DW-1:0]        data_out,
  output logic                 valid_out,
  output logic                 o_dbg_state
);

  localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);
  localparam logic [SW-1:0] LAST_IDX  = SW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            r_state, w_state_nx;
  logic [NREQ-1:0]   r_gnt, w_gnt_nx;
  logic [SW-1:0]     r_sel, w_sel_nx;
  logic [SW-1:0]     r_ptr, w_ptr_nx;
  logic [HW-1:0]     r_hold, w_hold_nx;
  logic [DW-1:0]     r_dout;
  logic              r_valid;

  logic [SW:0]       w_pick_idle;
  logic [SW:0]       w_pick_rel;
  logic [SW-1:0]     w_ptr_rel;
  logic              w_release;
  logic [DW-1:0]     w_sel_data;

  // Returns {found, index} of the first requester at or after start, wrapping.
  function automatic logic [SW:0] f_pick(input logic [NREQ-1:0] f_req,
                                         input logic [SW-1:0]   f_start);
    logic          f_found;
    logic [SW-1:0] f_idx;
    logic [SW-1:0] f_k;
    f_found = 1'b0;
    f_idx   = '0;
    f_k     = f_start;
    for (int i = 0; i < NREQ; i++) begin
      if (!f_found && f_req[f_k]) begin
        f_found = 1'b1;
        f_idx   = f_k;
      end
      f_k = (f_k == LAST_IDX) ? '0 : f_k + 1'b1;
    end
    return {f_found, f_idx};
  endfunction

  function automatic logic [NREQ-1:0] f_onehot(input logic [SW-1:0] f_idx);
    logic [NREQ-1:0] f_v;
    f_v        = '0;
    f_v[f_idx] = 1'b1;
    return f_v;
  endfunction

  // On release the owner hands priority to its successor, so it is searched last.
  assign w_ptr_rel   = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
  assign w_pick_idle = f_pick(req, r_ptr);
  assign w_pick_rel  = f_pick(req, w_ptr_rel);
  assign w_release   = !req[r_sel] || (r_hold == HOLD_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    w_hold_nx  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_pick_idle[SW]) begin
          w_state_nx = GRANT;
          w_gnt_nx   = f_onehot(w_pick_idle[SW-1:0]);
          w_sel_nx   = w_pick_idle[SW-1:0];
          w_hold_nx  = '0;
        end
      end
      GRANT: begin
        if (!w_release) begin
          w_hold_nx = r_hold + 1'b1;
        end else begin
          w_ptr_nx  = w_ptr_rel;
          w_hold_nx = '0;
          if (w_pick_rel[SW]) begin
            w_gnt_nx = f_onehot(w_pick_rel[SW-1:0]);
            w_sel_nx = w_pick_rel[SW-1:0];
          end else begin
            w_state_nx = IDLE;
            w_gnt_nx   = '0;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_sel == SW'(i)) w_sel_data = data_in[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_sel   <= w_sel_nx;
      r_ptr   <= w_ptr_nx;
      r_hold  <= w_hold_nx;
    end
  end

  // Datapath follows the pre-edge grant, so it lags gnt by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= |r_gnt;
      if (|r_gnt) r_dout <= w_sel_data;
    end
  end

  assign gnt         = r_gnt;
  assign sel         = r_sel;
  assign data_out    = r_dout;
  assign valid_out   = r_valid;
  assign o_dbg_state = (r_state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic against an
// owner/priority/cycle-count model, checked through expected-value queues.
module tb_mux_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 4;
  localparam int MAXHOLD = 4;
  localparam int SW      = 2;
  localparam int W       = NREQ + SW + 1 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    gnt;
  logic [SW-1:0]      sel;
  logic [DW-1:0]      data_out;
  logic               valid_out;
  logic               dbg_state;

  mux_rr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXHOLD(MAXHOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .gnt        (gnt),
    .sel        (sel),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] data_q[$];
  bit mon_en = 1'b0;

  // reference model: owner index (-1 = nobody), priority start, cycles owned so far
  int            m_owner;
  int            m_ptr;
  int            m_hold;
  logic [DW-1:0] m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_dout  = '0;
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] e_gnt;
    logic [SW-1:0]   e_sel;
    logic            e_valid;
    int              o;
    e_valid = (m_owner >= 0);
    if (m_owner >= 0) begin
      m_dout = data_in[m_owner*DW +: DW];
      data_q.push_back(m_dout);
    end
    if (m_owner < 0) begin
      o = search(req, m_ptr);
      if (o >= 0) begin
        m_owner = o;
        m_hold  = 1;
      end
    end else if (req[m_owner] && m_hold < MAXHOLD) begin
      m_hold++;
    end else begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = search(req, m_ptr);
      m_hold  = (m_owner >= 0) ? 1 : 0;
    end
    e_gnt = '0;
    e_sel = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_sel = SW'(m_owner);
    end
    exp_q.push_back({e_gnt, e_sel, e_valid, m_dout});
  endtask

  // driver: apply inputs, let one edge happen, model that edge
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
    req     = r;
    data_in = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0]    e;
    logic [NREQ-1:0] e_gnt;
    logic [SW-1:0]   e_sel;
    logic            e_valid;
    logic [DW-1:0]   e_dout;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {e_gnt, e_sel, e_valid, e_dout} = e;
      check("gnt", gnt, e_gnt);
      check("valid_out", valid_out, e_valid);
      check("data_out", data_out, e_dout);
      check("state", dbg_state, (e_gnt != 0));
      check("gnt_onehot0", $onehot0(gnt), 1);
      if (e_gnt != 0) check("sel", sel, e_sel);
      if (valid_out) begin
        if (data_q.size() == 0) check("data_q_underflow", 1, 0);
        else check("data_pop", data_out, data_q.pop_front());
      end
    end
  end

  logic [NREQ-1:0] r_rand;

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    data_in = '0;
    model_reset();
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // single requester
    repeat (2) cycle('0, NREQ*DW'($urandom));
    repeat (3) cycle(4'b0010, 16'h0010);
    repeat (3) cycle('0, NREQ*DW'($urandom));

    // full contention
    repeat (20) cycle(4'b1111, NREQ*DW'($urandom));

    // early drops and wrap
    repeat (3) cycle(4'b1100, NREQ*DW'($urandom));
    repeat (3) cycle(4'b1000, NREQ*DW'($urandom));
    repeat (4) cycle(4'b0101, NREQ*DW'($urandom));

    // sole requester through hold expiry, then idle return
    repeat (2) cycle('0, NREQ*DW'($urandom));
    repeat (10) cycle(4'b0001, NREQ*DW'($urandom));
    repeat (3) cycle('0, NREQ*DW'($urandom));

    // reset mid-grant
    repeat (2) cycle(4'b0100, 16'h0A00);
    check("pre_reset_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 0);
    check("async_rst_valid", valid_out, 0);
    check("async_rst_data", data_out, 0);
    exp_q.delete();
    data_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (4) cycle(4'b1100, NREQ*DW'($urandom));

    // random traffic with sticky request patterns
    r_rand = '0;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) r_rand = NREQ'($urandom);
      cycle(r_rand, NREQ*DW'($urandom));
    end
    repeat (2) cycle('0, NREQ*DW'($urandom));

    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
